// File: rtl/sp_ram_arbiter.sv
// sp_ram_arbiter
// Round-robin arbiter that serialises two request/grant masters (port 0:
// instruction fetch, port 1: data load/store) onto one single-port RAM.
// The grant is combinational, so the RAM samples the access in the grant
// cycle. The response (rvalid/rdata/err) is presented in the next cycle,
// which matches the RAM's one-cycle read latency. Accesses whose address
// has bits set above ADDR_WIDTH are granted but kept off the RAM, and they
// complete with an error response.

module sp_ram_arbiter #(
  parameter  int ADDR_WIDTH = 16,
  parameter  int DATA_WIDTH = 32,
  localparam int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  p0_req_i,
  output logic                  p0_gnt_o,
  input  logic [31:0]           p0_addr_i,
  input  logic                  p0_we_i,
  input  logic [BE_WIDTH-1:0]   p0_be_i,
  input  logic [DATA_WIDTH-1:0] p0_wdata_i,
  output logic                  p0_rvalid_o,
  output logic [DATA_WIDTH-1:0] p0_rdata_o,
  output logic                  p0_err_o,

  input  logic                  p1_req_i,
  output logic                  p1_gnt_o,
  input  logic [31:0]           p1_addr_i,
  input  logic                  p1_we_i,
  input  logic [BE_WIDTH-1:0]   p1_be_i,
  input  logic [DATA_WIDTH-1:0] p1_wdata_i,
  output logic                  p1_rvalid_o,
  output logic [DATA_WIDTH-1:0] p1_rdata_o,
  output logic                  p1_err_o,

  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [BE_WIDTH-1:0]   ram_be_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  // An address is backed by the RAM only when every bit above the RAM's
  // byte-address width is zero.
  function automatic logic addr_in_range(input logic [31:0] addr);
    return (addr[31:ADDR_WIDTH] == '0);
  endfunction

  // Arbitration state: 0 = port 0 preferred on contention.
  logic                  prio_r;
  logic                  prio_next_s;

  // Grant decision and the winning port's request fields.
  logic [1:0]            req_s;
  logic [1:0]            gnt_s;
  logic                  any_gnt_s;
  logic [31:0]           sel_addr_s;
  logic                  sel_we_s;
  logic [BE_WIDTH-1:0]   sel_be_s;
  logic [DATA_WIDTH-1:0] sel_wdata_s;
  logic                  sel_in_range_s;

  // Response pipeline stage (one cycle behind the grant).
  logic                  resp_valid_r;
  logic                  resp_port_r;
  logic                  resp_we_r;
  logic                  resp_err_r;
  logic [DATA_WIDTH-1:0] resp_data_s;

  assign req_s     = {p1_req_i, p0_req_i};
  assign any_gnt_s = |gnt_s;
  assign p0_gnt_o  = gnt_s[0];
  assign p1_gnt_o  = gnt_s[1];

  // Round-robin grant; nothing is granted while reset is asserted so that all
  // outputs read zero during reset even with requests pending.
  always_comb begin
    gnt_s = 2'b00;
    if (!rst_n) begin
      gnt_s = 2'b00;
    end else begin
      case (req_s)
        2'b01:   gnt_s = 2'b01;
        2'b10:   gnt_s = 2'b10;
        2'b11:   gnt_s = prio_r ? 2'b10 : 2'b01;
        default: gnt_s = 2'b00;
      endcase
    end
  end

  // Select the request fields of the granted port.
  always_comb begin
    sel_addr_s  = '0;
    sel_we_s    = 1'b0;
    sel_be_s    = '0;
    sel_wdata_s = '0;
    if (gnt_s[1]) begin
      sel_addr_s  = p1_addr_i;
      sel_we_s    = p1_we_i;
      sel_be_s    = p1_be_i;
      sel_wdata_s = p1_wdata_i;
    end else begin
      sel_addr_s  = p0_addr_i;
      sel_we_s    = p0_we_i;
      sel_be_s    = p0_be_i;
      sel_wdata_s = p0_wdata_i;
    end
  end

  assign sel_in_range_s = addr_in_range(sel_addr_s);

  // Drive the RAM with the granted in-range access. The RAM stays idle with
  // all fields at zero when there is no grant or the access is out of range,
  // so an out-of-range write never reaches the array.
  always_comb begin
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (any_gnt_s && sel_in_range_s) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = sel_addr_s[ADDR_WIDTH-1:0];
      ram_we_o    = sel_we_s;
      ram_be_o    = sel_be_s;
      ram_wdata_o = sel_wdata_s;
    end else begin
      ram_en_o    = 1'b0;
      ram_addr_o  = '0;
      ram_we_o    = 1'b0;
      ram_be_o    = '0;
      ram_wdata_o = '0;
    end
  end

  // Next priority: the port that did not just win is preferred next time.
  always_comb begin
    prio_next_s = prio_r;
    if (any_gnt_s) begin
      prio_next_s = ~gnt_s[1];
    end else begin
      prio_next_s = prio_r;
    end
  end

  // Priority register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_r <= 1'b0;
    end else begin
      prio_r <= prio_next_s;
    end
  end

  // Capture the attributes of each granted access for its response cycle.
  // The register clears when there is no grant, so each response lasts
  // exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid_r <= 1'b0;
      resp_port_r  <= 1'b0;
      resp_we_r    <= 1'b0;
      resp_err_r   <= 1'b0;
    end else if (any_gnt_s) begin
      resp_valid_r <= 1'b1;
      resp_port_r  <= gnt_s[1];
      resp_we_r    <= sel_we_s;
      resp_err_r   <= ~sel_in_range_s;
    end else begin
      resp_valid_r <= 1'b0;
      resp_port_r  <= 1'b0;
      resp_we_r    <= 1'b0;
      resp_err_r   <= 1'b0;
    end
  end

  // Only an in-range read returns RAM data; writes and errors return zero.
  always_comb begin
    resp_data_s = '0;
    if (resp_valid_r && !resp_we_r && !resp_err_r) begin
      resp_data_s = ram_rdata_i;
    end else begin
      resp_data_s = '0;
    end
  end

  // Steer the response to the port that owns it; the other port reads zero.
  always_comb begin
    p0_rvalid_o = 1'b0;
    p0_rdata_o  = '0;
    p0_err_o    = 1'b0;
    p1_rvalid_o = 1'b0;
    p1_rdata_o  = '0;
    p1_err_o    = 1'b0;
    if (resp_valid_r) begin
      case (resp_port_r)
        1'b0: begin
          p0_rvalid_o = 1'b1;
          p0_rdata_o  = resp_data_s;
          p0_err_o    = resp_err_r;
        end
        1'b1: begin
          p1_rvalid_o = 1'b1;
          p1_rdata_o  = resp_data_s;
          p1_err_o    = resp_err_r;
        end
        default: begin
          p0_rvalid_o = 1'b0;
          p1_rvalid_o = 1'b0;
        end
      endcase
    end else begin
      p0_rvalid_o = 1'b0;
      p1_rvalid_o = 1'b0;
    end
  end

endmodule
